pipe_skid_latch: RTL
====================

PIPE_SKID_LATCH -- requirements
Module: pipe_skid_latch

Interface
REQ-001 Parameter WIDTH, default 341, payload bits per entry (one full stage bundle).
REQ-002 Parameter DEPTH, default 2, entry count; legal range 1..8; CW = clog2(DEPTH+1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_data  input  WIDTH  payload from upstream stage.
REQ-006 in_v  input  1  upstream entry valid.
REQ-007 in_rdy  output  1  space available; upstream may present an entry this cycle.
REQ-008 out_data  output  WIDTH  payload of oldest held entry.
REQ-009 out_v  output  1  oldest entry valid.
REQ-010 out_rdy  input  1  downstream not stalled; consumes out_data when out_v=1.
REQ-011 flush  input  1  invalidate all held entries (branch mispredict / exception).
REQ-012 count  output  CW  number of held entries.

Function
REQ-013 Storage SHALL be a circular buffer of DEPTH entries with a write pointer, a read pointer and an occupancy counter; pointers wrap from DEPTH-1 to 0, including for non-power-of-2 DEPTH.
REQ-014 in_rdy SHALL equal (count < DEPTH), decoded from registered state only; no combinational path from out_rdy or flush to in_rdy.
REQ-015 Push SHALL occur when in_v=1, in_rdy=1 and flush=0: in_data written at write pointer, write pointer advances.
REQ-016 Pop SHALL occur when out_v=1, out_rdy=1 and flush=0: read pointer advances.
REQ-017 out_v SHALL equal (count != 0); out_data SHALL equal the entry at the read pointer when out_v=1 and all-zero when out_v=0.
REQ-018 Latency: an entry pushed in cycle N SHALL be visible on out_data/out_v in cycle N+1 at the earliest; no same-cycle in-to-out bypass.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-020 When full (count=DEPTH), in_rdy=0 even if out_rdy=1 that cycle; a pop from full frees the slot for the next cycle.
REQ-021 When empty, out_rdy SHALL have no effect; count SHALL never underflow or exceed DEPTH.
REQ-022 in_v=1 while in_rdy=0 SHALL not modify state; upstream holds in_data/in_v until accepted.
REQ-023 flush=1 SHALL, at the next edge, set count=0 and both pointers to 0; a push or pop presented in the flush cycle SHALL be discarded.
REQ-024 Flush SHALL have priority over push and pop; outputs in the flush cycle still reflect pre-flush state.
REQ-025 Entry storage need not be cleared on flush; out_data SHALL still read zero while empty (REQ-017).
REQ-026 DEPTH=1 SHALL behave as a single-entry stage latch with full bubble: in_rdy=0 whenever an entry is held.

Reset
REQ-027 While rst=1: count=0, pointers=0, out_v=0, out_data=0, in_rdy=1, regardless of clk.
REQ-028 Assertion of rst mid-operation SHALL discard all entries immediately (asynchronously); the first push after deassertion lands in entry 0.
REQ-029 Storage array contents SHALL be reset to zero.

Verification (WIDTH=8, DEPTH=2 unless stated)
REQ-030 Reset, then push 0xA5 with out_rdy=0 -> next cycle out_v=1, out_data=0xA5, count=1, in_rdy=1.
REQ-031 Push 0x11, 0x22 with out_rdy=0 -> count=2, in_rdy=0; hold in_v=1 with 0x33, raise out_rdy -> pops 0x11, then 0x22 at head, 0x33 accepted the following cycle; order 0x11,0x22,0x33 out.
REQ-032 Streaming: in_v=1, out_rdy=1 every cycle with values 1..10 -> count stays 1 after the first push, out_data sequence 1..10 with one cycle latency, no loss.
REQ-033 count=2, assert flush together with in_v=1 (0x77) and out_rdy=1 -> next cycle count=0, out_v=0, out_data=0x00; 0x77 absent.
REQ-034 DEPTH=3: push/pop 7 entries with random out_rdy -> pointer wrap from 2 to 0 exercised, FIFO order preserved, count never >3.
REQ-035 Assert rst asynchronously between edges with count=2 -> out_v drops to 0 and count=0 before the next edge; first post-reset push reads back correctly.

Source files
------------

// File: rtl/pipe_skid_latch.sv
// Circular-buffer stage latch: DEPTH entries, one cycle in-to-out latency, no bypass.
// in_rdy comes from registered occupancy only; flush wins over push/pop and empties the buffer.
module pipe_skid_latch #(
  parameter int WIDTH = 341,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_v,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_v,
  input  logic             out_rdy,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;

  // Pointers wrap explicitly so non-power-of-2 depths stay in range.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_rdy   = (count_q < CW'(DEPTH));
  assign out_v    = (count_q != '0);
  assign out_data = out_v ? mem[rd_ptr] : '0;
  assign count    = count_q;

  assign push = in_v & in_rdy & ~flush;
  assign pop  = out_v & out_rdy & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Stale entries survive a flush; out_data is masked while empty instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule
